echo_timer: RTL
===============

// Module: echo_timer
// PURPOSE
//  Ultrasonic-ranger front end for the radar: issues the trigger pulse, then times the returned echo.
//  Consumes the sensor side of the trigger/echo interface. Reports echo width in microseconds and distance in cm.
//  Sits between the sensor pins and the radar sweep/display logic. Uses its own restartable 1 us tick.
// PARAMETERS
//  CLK_FREQ    100_000_000  input clock frequency, Hz
//  TICK_FREQ   1_000_000    measurement tick, Hz (1 us resolution); DIV = CLK_FREQ/TICK_FREQ, integer, >=2
//  TRIG_US     10           trigger high time, us
//  TIMEOUT_US  30000        max wait for echo rise, and max echo width, us
//  W           16           width_us / internal counter width; must hold TIMEOUT_US
// PORTS
//  clk_int   in   1   system clock
//  rst_n     in   1   asynchronous, active-low reset
//  start     in   1   request one measurement; sampled only in IDLE
//  echo      in   1   sensor echo, asynchronous to clk_int
//  trig      out  1   sensor trigger pulse
//  busy      out  1   high from accepted start until the cycle after valid
//  valid     out  1   one-cycle pulse: results updated
//  timeout   out  1   result flag: no echo, or echo exceeded TIMEOUT_US
//  width_us  out  W   echo high time, us, truncated
//  dist_cm   out  10  (width_us*1130)>>16, truncated (~width_us/58)
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; trig, busy and valid = 0; timeout = 0; width_us = 0; dist_cm = 0;
//   all counters and synchronizer flops = 0. Reset during any state aborts immediately, with trig low at once.
//  echo passes a 2-FF synchronizer. Edge detection uses synced vs. 1-cycle-delayed value. Adds 2 cycles of latency.
//  Tick gen: counts 0..DIV-1 and pulses tick when it reaches DIV-1. It is cleared to 0 on entry to TRIG, WAIT and MEAS.
//  FSM:
//   IDLE : busy=0. start=1 -> TRIG; us_cnt=0.
//   TRIG : trig=1, busy=1. After TRIG_US ticks (exactly TRIG_US*DIV cycles) -> WAIT; trig=0 on that edge.
//   WAIT : count ticks. Synced echo rising edge -> MEAS; us_cnt=0.
//          us_cnt==TIMEOUT_US -> DONE with timeout=1, width_us=0.
//          echo already high on entry is not an edge; that time counts toward the timeout.
//   MEAS : us_cnt++ per tick while echo high. Synced echo falling edge -> DONE; width_us=us_cnt.
//          us_cnt reaching TIMEOUT_US -> DONE; timeout=1, width_us=TIMEOUT_US (saturate, no wrap).
//   DONE : one cycle. Register width_us, dist_cm and timeout; pulse valid=1 -> IDLE (busy drops the next cycle).
//  Rising and falling edges on the same tick cycle: the edge wins over the tick increment and over the timeout.
//  start while busy: ignored, not queued. start held high: a new measurement begins the cycle after DONE->IDLE.
//  Results hold their value between valid pulses. A non-timeout result always has timeout=0.
//  dist_cm: 16x11-bit multiply with a 27-bit product; bits [25:16] are registered in DONE. Max 517 at W=16.
//  Accuracy: width_us is within -1/+0 us of true echo width, plus 2 clk of synchronizer delay.
// STRUCTURE
//  Shared header radar_defs.vh: FSM state encodings (IDLE, TRIG, WAIT, MEAS, DONE), RECIP_58 = 11'd1130, and CLK_FREQ default.
//  Sub-module us_tick_gen (params CLK_FREQ, TICK_FREQ; ports clk_int, rst_n, clr, tick). Everything else is inline.
// TESTING  (CLK_FREQ=100MHz, TICK_FREQ=1MHz, TRIG_US=10, TIMEOUT_US=30000)
//  1. Reset, then start=1 for 1 cycle -> trig high for exactly 1000 clk, busy=1; no valid.
//  2. Echo high 580 us, 50 us after trig falls -> valid 1 pulse, width_us=580, dist_cm=10, timeout=0.
//  3. Echo high 1160 us -> width_us=1160, dist_cm=20. Then echo 0.5 us -> width_us=0, dist_cm=0.
//  4. No echo -> valid at 30000 us after trig fall; timeout=1, width_us=0, dist_cm=0.
//  5. Echo stuck high 40000 us -> timeout=1, width_us=30000, dist_cm=517. Echo high before trig -> treated as no echo.
//  6. start pulsed mid-MEAS -> ignored. rst_n low mid-TRIG -> trig=0 same cycle, all outputs 0.
//     Next start after reset measures normally.

Source files
------------

// File: rtl/echo_timer_pkg.sv
// +----------------------------------------------------------------------+
// | echo_timer_pkg : shared FSM encoding and constants for echo_timer    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package echo_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TRIG = 3'd1,
    ST_WAIT = 3'd2,
    ST_MEAS = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // 2^16/58 rounded: dist_cm = (width_us * RECIP_58) >> 16
  localparam logic [10:0] RECIP_58         = 11'd1130;
  localparam int          CLK_FREQ_DEFAULT = 100_000_000;

endpackage

`default_nettype wire

// File: rtl/echo_timer_us_tick_gen.sv
// +----------------------------------------------------------------------+
// | us_tick_gen : restartable divider producing a 1-cycle tick per period |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module us_tick_gen
  import echo_timer_pkg::*;
#(
  parameter int CLK_FREQ  = CLK_FREQ_DEFAULT,
  parameter int TICK_FREQ = 1_000_000
) (
  input  logic clk_int,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int DIV = CLK_FREQ / TICK_FREQ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] c_last_cnt = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == c_last_cnt)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == c_last_cnt);

endmodule

`default_nettype wire

// File: rtl/echo_timer.sv
// +----------------------------------------------------------------------+
// | echo_timer : ultrasonic ranger trigger generator and echo timer      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module echo_timer
  import echo_timer_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEFAULT,
  parameter int TICK_FREQ  = 1_000_000,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int W          = 16
) (
  input  logic         clk_int,
  input  logic         rst_n,
  input  logic         start,
  input  logic         echo,
  output logic         trig,
  output logic         busy,
  output logic         valid,
  output logic         timeout,
  output logic [W-1:0] width_us,
  output logic [9:0]   dist_cm
);

  localparam logic [W-1:0] c_trig_last = W'(TRIG_US - 1);
  localparam logic [W-1:0] c_timeout   = W'(TIMEOUT_US);

  state_t       r_state;
  logic [1:0]   r_sync;
  logic         r_echo_d;
  logic [W-1:0] r_us_cnt;
  logic [W-1:0] r_res;
  logic         r_res_to;
  logic         r_trig;
  logic         r_busy;
  logic         r_valid;
  logic         r_timeout;
  logic [W-1:0] r_width;
  logic [9:0]   r_dist;

  logic w_tick;
  logic w_rise;
  logic w_fall;
  logic w_trig_done;
  logic w_clr;
  logic [9:0] w_dist;

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= 2'b00;
      r_echo_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], echo};
      r_echo_d <= r_sync[1];
    end
  end

  assign w_rise      = r_sync[1] & ~r_echo_d;
  assign w_fall      = ~r_sync[1] & r_echo_d;
  assign w_trig_done = (r_state == ST_TRIG) && w_tick && (r_us_cnt == c_trig_last);
  // Restart the tick phase on every entry to TRIG, WAIT and MEAS
  assign w_clr       = ((r_state == ST_IDLE) && start) || w_trig_done ||
                       ((r_state == ST_WAIT) && w_rise);
  assign w_dist      = 10'((27'(r_res) * 27'(RECIP_58)) >> 16);

  us_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .TICK_FREQ (TICK_FREQ)
  ) u_tick (
    .clk_int (clk_int),
    .rst_n   (rst_n),
    .clr     (w_clr),
    .tick    (w_tick)
  );

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_us_cnt  <= '0;
      r_res     <= '0;
      r_res_to  <= 1'b0;
      r_trig    <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_width   <= '0;
      r_dist    <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_busy <= start;
          r_trig <= start;
          if (start) begin
            r_state  <= ST_TRIG;
            r_us_cnt <= '0;
          end
        end
        ST_TRIG: begin
          if (w_trig_done) begin
            r_state  <= ST_WAIT;
            r_trig   <= 1'b0;
            r_us_cnt <= '0;
          end else if (w_tick) begin
            r_us_cnt <= r_us_cnt + W'(1);
          end
        end
        ST_WAIT: begin
          if (w_rise) begin
            r_state  <= ST_MEAS;
            r_us_cnt <= '0;
          end else if (r_us_cnt == c_timeout) begin
            r_state  <= ST_DONE;
            r_res    <= '0;
            r_res_to <= 1'b1;
          end else if (w_tick) begin
            r_us_cnt <= r_us_cnt + W'(1);
          end
        end
        ST_MEAS: begin
          // A falling edge beats both the tick and the timeout in the same cycle
          if (w_fall) begin
            r_state  <= ST_DONE;
            r_res    <= r_us_cnt;
            r_res_to <= 1'b0;
          end else if (r_us_cnt == c_timeout) begin
            r_state  <= ST_DONE;
            r_res    <= c_timeout;
            r_res_to <= 1'b1;
          end else if (w_tick) begin
            r_us_cnt <= r_us_cnt + W'(1);
          end
        end
        ST_DONE: begin
          r_width   <= r_res;
          r_dist    <= w_dist;
          r_timeout <= r_res_to;
          r_valid   <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_trig  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign trig     = r_trig;
  assign busy     = r_busy;
  assign valid    = r_valid;
  assign timeout  = r_timeout;
  assign width_us = r_width;
  assign dist_cm  = r_dist;

endmodule

`default_nettype wire
